addr8u_residue_checker: RTL

//  Downstream checking stage for the 8-bit unsigned adder.
//  - Accepts operands A, B and the adder's 9-bit result O through a valid/ready handshake.
//  - Verifies O with a mod-3 residue check, (A+B) mod 3 == O mod 3, and forwards O with an error tag.
//  - Counts detected faults so that fault-resilience campaigns are measured in-system.
//  - Guarantee: every single-bit error on O is detected (2^k is never divisible by 3).
//  - Not detected: errors whose value is a multiple of 3.

---
 rtl/addr8u_chk_pkg.sv | 11 +
 rtl/mod3_residue.sv | 15 +
 rtl/addr8u_residue_checker.sv | 71 +++++++
 3 files changed

// File: rtl/addr8u_chk_pkg.sv
// addr8u_chk_pkg: shared widths, residue type and mod-3 residue addition
package addr8u_chk_pkg;
  localparam int OP_W = 8;
  localparam int SUM_W = 9;
  typedef logic [1:0] residue_t;
  function automatic residue_t res_add_mod3(input residue_t a, input residue_t b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 3'd3) ? residue_t'(s - 3'd3) : s[1:0];
  endfunction
endpackage

// File: rtl/mod3_residue.sv
// mod3_residue: combinational W-bit value to mod-3 residue using +1/-1 alternating bit weights
module mod3_residue
  import addr8u_chk_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  output residue_t     r
);
  always_comb begin
    r = '0;
    for (int i = 0; i < W; i++)
      if (x[i]) r = res_add_mod3(r, (i % 2 == 1) ? 2'd2 : 2'd1);
  end
endmodule

// File: rtl/addr8u_residue_checker.sv
// addr8u_residue_checker: two-stage valid/ready mod-3 residue checker for the 8-bit adder with fault counter
module addr8u_residue_checker
  import addr8u_chk_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OP_W-1:0]      op_a,
  input  logic [OP_W-1:0]      op_b,
  input  logic [SUM_W-1:0]     sum_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SUM_W-1:0]     out_sum,
  output logic                 out_err,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_cnt,
  input  logic                 err_clr
);
  logic s0_full, s1_full, s1_err;
  logic [OP_W-1:0] s0_a, s0_b;
  logic [SUM_W-1:0] s0_sum, s1_sum;
  residue_t r_a, r_b, r_o;
  logic s1_load, s0_move, accept, emit_err;
  mod3_residue #(.W(OP_W)) u_res_a (.x(s0_a), .r(r_a));
  mod3_residue #(.W(OP_W)) u_res_b (.x(s0_b), .r(r_b));
  mod3_residue #(.W(SUM_W)) u_res_o (.x(s0_sum), .r(r_o));
  assign s1_load = !s1_full | out_ready;
  assign s0_move = s0_full & s1_load;
  assign in_ready = rst_n & (!s0_full | s1_load);
  assign accept = in_valid & in_ready;
  assign emit_err = s1_full & out_ready & s1_err;
  assign out_valid = s1_full;
  assign out_sum = s1_sum;
  assign out_err = s1_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_full <= 1'b0;
      s0_a <= '0;
      s0_b <= '0;
      s0_sum <= '0;
      s1_full <= 1'b0;
      s1_sum <= '0;
      s1_err <= 1'b0;
    end else begin
      if (s1_load) s1_full <= s0_full;
      if (s0_move) begin
        s1_sum <= s0_sum;
        s1_err <= res_add_mod3(r_a, r_b) != r_o;
      end
      if (!s0_full | s1_load) s0_full <= in_valid;
      if (accept) begin
        s0_a <= op_a;
        s0_b <= op_b;
        s0_sum <= sum_in;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
      err_cnt <= '0;
    end else begin
      err_sticky <= emit_err | (err_sticky & !err_clr);
      err_cnt <= emit_err ? (err_clr ? ERR_CNT_W'(1) : (&err_cnt ? err_cnt : err_cnt + 1'b1))
                          : (err_clr ? '0 : err_cnt);
    end
  end
endmodule
